// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited request issue, in-order response buffer,
// and redirect handling that drains responses belonging to the abandoned path.
module fetch_stage #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [15:0]     imem_rdata,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            stall,
  output logic [15:0]     instr,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_valid
);

  localparam int              CW      = $clog2(DEPTH + 1);
  localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   LAST    = PW'(DEPTH - 1);
  localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);

  typedef enum logic {FETCH, FLUSH} state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   count;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   flush_cnt;
  logic [15:0]     buf_data [DEPTH];
  logic [PC_W-1:0] buf_pc   [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic            grant;
  logic            push;
  logic            pop;
  logic [PC_W-1:0] resp_pc;

  // Every in-flight fetch owns a buffer slot, so a response can never find the buffer full.
  assign imem_req  = rst_n && (state == FETCH) && !redirect &&
                     (({1'b0, outstanding} + {1'b0, count}) < DEPTH_C);
  assign imem_addr = pc;

  assign grant     = imem_req && imem_gnt;
  assign push      = imem_rvalid && (state == FETCH) && (drop == '0);
  assign pop       = instr_valid && !stall;

  // In FETCH the in-flight requests are the consecutive addresses just below pc.
  assign resp_pc   = pc - PC_W'(outstanding);
  assign flush_cnt = imem_rvalid ? outstanding - 1'b1 : outstanding;

  assign instr_valid = (count != '0);
  assign instr       = buf_data[head];
  assign instr_pc    = buf_pc[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      outstanding <= '0;
      count       <= '0;
      drop        <= '0;
      head        <= '0;
      tail        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else if (redirect) begin
      pc          <= redirect_pc;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      outstanding <= flush_cnt;
      drop        <= flush_cnt;
      state       <= (flush_cnt != '0) ? FLUSH : FETCH;
    end else begin
      if (grant) begin
        pc <= pc + 1'b1;
      end
      outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
      if ((state == FLUSH) && imem_rvalid) begin
        drop <= drop - 1'b1;
        if (drop == CW'(1)) begin
          state <= FETCH;
        end
      end
      if (push) begin
        buf_data[tail] <= imem_rdata;
        buf_pc[tail]   <= resp_pc;
        tail           <= (tail == LAST) ? '0 : tail + 1'b1;
      end
      if (pop) begin
        head <= (head == LAST) ? '0 : head + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a tagged in-order memory model and a queue-based view of
// what decode should see, driven with directed and randomized grant/stall/redirect traffic.
module tb_fetch_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid, redirect, stall, instr_valid;
  logic [7:0]  imem_addr, redirect_pc, instr_pc;
  logic [15:0] imem_rdata, instr;

  logic        imem_req2, imem_gnt2, imem_rvalid2, instr_valid2;
  logic [7:0]  imem_addr2, instr_pc2;
  logic [15:0] imem_rdata2, instr2;

  always #5 clk = ~clk;

  fetch_stage #(.PC_W(8), .RESET_PC(8'h00), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  fetch_stage #(.PC_W(8), .RESET_PC(8'hFE), .DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_gnt(imem_gnt2), .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
    .redirect(1'b0), .redirect_pc(8'h00), .stall(1'b0),
    .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2)
  );

  // A fetch in flight remembers which control-flow path (epoch) issued it.
  typedef struct { logic [7:0] addr; int epoch; int due; } pend_t;
  typedef struct { logic [7:0] addr; logic [15:0] data; } ent_t;

  pend_t       pending[$];
  ent_t        q[$];
  logic [15:0] seen[$];
  logic [7:0]  seen_pc[$];
  logic [7:0]  model_pc;
  int          epoch, cyc, last_due, lat;
  bit          w_pend;
  logic [7:0]  w_addr;
  int          checks, errors;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return 16'h1000 + {8'h00, a};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; redirect = 0; redirect_pc = '0; stall = 0;
    imem_gnt2 = 0; imem_rvalid2 = 0; imem_rdata2 = '0;
    pending.delete(); q.delete(); seen.delete(); seen_pc.delete();
    model_pc = 8'h00; epoch = 0; last_due = 0; w_pend = 0; w_addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive at the falling edge, compare against the model, then advance the model.
  task automatic step(input bit g, input bit s, input bit r, input logic [7:0] rpc);
    bit         rv, flushing, exp_req, exp_valid;
    logic [7:0] raddr;
    pend_t      p;
    int         due;
    p = '{addr: 8'h00, epoch: 0, due: 0};
    @(negedge clk);
    imem_gnt = g; stall = s; redirect = r; redirect_pc = rpc;
    rv = 0; raddr = '0;
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      rv = 1; raddr = pending[0].addr;
    end
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(raddr) : 16'h0000;
    imem_gnt2    = 1'b1;
    imem_rvalid2 = w_pend;
    imem_rdata2  = mem_word(w_addr);
    #1;
    w_pend = imem_req2;
    w_addr = imem_addr2;

    flushing = 0;
    for (int i = 0; i < pending.size(); i++) if (pending[i].epoch != epoch) flushing = 1;
    exp_req   = !r && !flushing && ((pending.size() + q.size()) < DEPTH);
    exp_valid = (q.size() > 0);

    checks++;
    if (instr_valid !== exp_valid) begin
      errors++; $display("[TB] FAIL instr_valid cyc %0d: got %b expected %b", cyc, instr_valid, exp_valid);
    end
    checks++;
    if (imem_req !== exp_req) begin
      errors++; $display("[TB] FAIL imem_req cyc %0d: got %b expected %b", cyc, imem_req, exp_req);
    end
    checks++;
    if (imem_addr !== model_pc) begin
      errors++; $display("[TB] FAIL imem_addr cyc %0d: got %0h expected %0h", cyc, imem_addr, model_pc);
    end
    if (exp_valid) begin
      checks++;
      if (instr !== q[0].data) begin
        errors++; $display("[TB] FAIL instr cyc %0d: got %0h expected %0h", cyc, instr, q[0].data);
      end
      checks++;
      if (instr_pc !== q[0].addr) begin
        errors++; $display("[TB] FAIL instr_pc cyc %0d: got %0h expected %0h", cyc, instr_pc, q[0].addr);
      end
    end
    if (!r && !s && instr_valid === 1'b1) begin
      seen.push_back(instr);
      seen_pc.push_back(instr_pc);
    end

    if (rv) p = pending.pop_front();
    if (r) begin
      q.delete();
      epoch++;
      model_pc = rpc;
    end else begin
      if (q.size() > 0 && !s) void'(q.pop_front());
      if (rv && p.epoch == epoch) q.push_back('{addr: p.addr, data: mem_word(p.addr)});
      if (exp_req && g) begin
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pending.push_back('{addr: model_pc, epoch: epoch, due: due});
        model_pc = model_pc + 8'h01;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); end
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
    checks++;
    if (instr !== 16'h0000 || instr_pc !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_instr: got %0h/%0h expected 0/0", instr, instr_pc);
    end
    checks++;
    if (imem_addr !== 8'h00 || imem_addr2 !== 8'hFE) begin
      errors++; $display("[TB] FAIL reset_pc: got %0h/%0h expected 0/fe", imem_addr, imem_addr2);
    end
    do_reset();
    #1;
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL req_after_release: got %b expected 1", imem_req); end
  endtask

  task automatic test_stream();
    lat = 1;
    repeat (12) step(1, 0, 0, 8'h00);
    checks++;
    if (seen.size() < 4) begin
      errors++; $display("[TB] FAIL stream_count: got %0d expected >=4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (seen[i] !== 16'h1000 + 16'(i) || seen_pc[i] !== 8'(i)) begin
          errors++; $display("[TB] FAIL stream_%0d: got %0h@%0h expected %0h@%0h", i, seen[i], seen_pc[i], 16'h1000 + 16'(i), i);
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    lat = 1;
    repeat (5) step(1, 1, 0, 8'h00);
    #1;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'h1000 || imem_req !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_hold: got v=%b i=%0h req=%b expected v=1 i=1000 req=0", instr_valid, instr, imem_req);
    end
    repeat (10) step(1, 0, 0, 8'h00);
    checks++;
    if (seen.size() < 3 || seen[0] !== 16'h1000) begin
      errors++; $display("[TB] FAIL stall_resume: got %0d items expected first 1000", seen.size());
    end else begin
      for (int i = 1; i < seen.size(); i++) begin
        checks++;
        if (seen_pc[i] !== seen_pc[i-1] + 8'h01) begin
          errors++; $display("[TB] FAIL stall_order_%0d: got %0h expected %0h", i, seen_pc[i], seen_pc[i-1] + 8'h01);
        end
      end
    end
  endtask

  task automatic test_redirect_flush();
    bit found;
    do_reset();
    lat = 3; found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (pending.size() == 2 && pending[0].due > cyc) begin
        step(1, 0, 1, 8'h40); found = 1;
      end else step(1, 0, 0, 8'h00);
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL flush_setup: got no 2-outstanding window expected one"); end
    step(1, 0, 0, 8'h00);
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL flush_req: got %b expected 0", imem_req); end
    seen.delete(); seen_pc.delete();
    repeat (15) step(1, 0, 0, 8'h00);
    checks++;
    if (seen.size() == 0 || seen_pc[0] !== 8'h40 || seen[0] !== 16'h1040) begin
      errors++; $display("[TB] FAIL flush_first: got %0d items expected first 1040@40", seen.size());
    end
  endtask

  task automatic test_redirect_rvalid();
    bit found;
    do_reset();
    lat = 2; found = 0;
    for (int n = 0; n < 30 && !found; n++) begin
      if (pending.size() > 0 && pending[0].due <= cyc && q.size() > 0) begin
        step(1, 0, 1, 8'h80); found = 1;
      end else step(1, 0, 0, 8'h00);
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL rv_redirect_setup: got no window expected one"); end
    #1;
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rv_redirect_empty: got %b expected 0", instr_valid); end
    repeat (10) step(1, 0, 0, 8'h00);
  endtask

  task automatic test_random();
    do_reset();
    repeat (400) begin
      lat = $urandom_range(1, 4);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
           8'($urandom_range(0, 255)));
    end
    lat = 1;
    repeat (10) step(1, 0, 0, 8'h00);
  endtask

  task automatic test_wrap();
    logic [7:0]  pcs[$];
    logic [15:0] ins[$];
    logic [7:0]  exp_pc;
    do_reset();
    lat = 1;
    for (int n = 0; n < 20 && pcs.size() < 3; n++) begin
      step(0, 0, 0, 8'h00);
      #1;
      if (instr_valid2 === 1'b1) begin pcs.push_back(instr_pc2); ins.push_back(instr2); end
    end
    checks++;
    if (pcs.size() < 3) begin
      errors++; $display("[TB] FAIL wrap_count: got %0d expected 3", pcs.size());
    end else begin
      exp_pc = 8'hFE;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (pcs[i] !== exp_pc || ins[i] !== mem_word(exp_pc)) begin
          errors++; $display("[TB] FAIL wrap_%0d: got %0h@%0h expected %0h@%0h", i, ins[i], pcs[i], mem_word(exp_pc), exp_pc);
        end
        exp_pc = exp_pc + 8'h01;
      end
    end
  endtask

  task automatic test_async_reset();
    bit full;
    do_reset();
    lat = 1; full = 0;
    for (int n = 0; n < 10 && !full; n++) begin
      step(1, 1, 0, 8'h00);
      full = (q.size() == 2);
    end
    checks++;
    if (!full) begin errors++; $display("[TB] FAIL areset_setup: got %0d buffered expected 2", q.size()); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 8'h00) begin
      errors++; $display("[TB] FAIL areset_now: got v=%b req=%b a=%0h expected 0 0 0", instr_valid, imem_req, imem_addr);
    end
    do_reset();
    repeat (6) step(1, 0, 0, 8'h00);
    checks++;
    if (seen.size() == 0 || seen[0] !== 16'h1000 || seen_pc[0] !== 8'h00) begin
      errors++; $display("[TB] FAIL areset_restart: got %0d items expected first 1000@0", seen.size());
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; lat = 1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_redirect_rvalid();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
